// File: rtl/sram_ctrl.sv
// Single-port SRAM macro controller: one host request at a time, registered macro pins.
// Latency: a write issues 1 cycle after acceptance; read data is valid 3 cycles after acceptance.
// Backpressure: req_ready is high only when idle; a read response holds until rsp_ready.
//
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   req_valid/req_ready           host request handshake (req_we, req_addr, req_wdata)
//   rsp_valid/rsp_ready           read response handshake (rsp_rdata)
//   sram_cen/gwen/a/d, sram_q     macro access pins and macro read data
//   sram_stov..sram_wablm         fixed margin/retention pins
//   busy                          controller is not idle
// Optional feature: define SRAM_CTRL_INIT_EN to zero-fill the whole array after every reset.

module sram_ctrl #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          sram_cen,
    output logic          sram_gwen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    output logic          sram_stov,
    output logic [2:0]    sram_ema,
    output logic [1:0]    sram_emaw,
    output logic          sram_emas,
    output logic          sram_ret1n,
    output logic          sram_wabl,
    output logic [1:0]    sram_wablm,
    input  logic [DW-1:0] sram_q,
    output logic          busy
);

    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
`ifdef SRAM_CTRL_INIT_EN
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_RESET = S_INIT;
`else
    localparam logic [2:0] S_RESET = S_IDLE;
`endif

    logic [2:0] state;

`ifdef SRAM_CTRL_INIT_EN
    logic [AW-1:0] init_addr;
`endif

    // Fixed margin settings for the macro.
    assign sram_stov  = 1'b0;
    assign sram_ema   = 3'b011;
    assign sram_emaw  = 2'b01;
    assign sram_emas  = 1'b0;
    assign sram_ret1n = 1'b1;
    assign sram_wabl  = 1'b0;
    assign sram_wablm = 2'b00;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_RESET;
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_a    <= '0;
            sram_d    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef SRAM_CTRL_INIT_EN
            init_addr <= '0;
`endif
        end else begin
            // The macro is only enabled for the single cycle after an access is scheduled.
            sram_cen <= 1'b1;
            case (state)
`ifdef SRAM_CTRL_INIT_EN
                S_INIT: begin
                    sram_cen  <= 1'b0;
                    sram_gwen <= 1'b0;
                    sram_a    <= init_addr;
                    sram_d    <= '0;
                    // Stop at the top address instead of wrapping; the last
                    // write is presented during the first IDLE cycle.
                    if (init_addr == {AW{1'b1}}) begin
                        state <= S_IDLE;
                    end else begin
                        init_addr <= init_addr + 1'b1;
                    end
                end
`endif
                S_IDLE: begin
                    if (req_valid) begin
                        state     <= S_ISSUE;
                        sram_cen  <= 1'b0;
                        sram_gwen <= ~req_we;
                        sram_a    <= req_addr;
                        if (req_we) begin
                            sram_d <= req_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    // gwen still holds the direction of the access being issued.
                    state <= sram_gwen ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    // Macro output is valid in the cycle after the read edge.
                    rsp_rdata <= sram_q;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed sequences plus random traffic against a reference model.
// Latency: expected responses at handshake + 3 cycles, macro access at handshake + 1 cycle.
// Backpressure: rsp_ready is held low or randomized to exercise response stalls.

module tb_sram_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cen;
    logic          sram_gwen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic          sram_stov;
    logic [2:0]    sram_ema;
    logic [1:0]    sram_emaw;
    logic          sram_emas;
    logic          sram_ret1n;
    logic          sram_wabl;
    logic [1:0]    sram_wablm;
    logic [DW-1:0] sram_q;
    logic          busy;

    sram_ctrl #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_a(sram_a), .sram_d(sram_d),
        .sram_stov(sram_stov), .sram_ema(sram_ema), .sram_emaw(sram_emaw),
        .sram_emas(sram_emas), .sram_ret1n(sram_ret1n), .sram_wabl(sram_wabl),
        .sram_wablm(sram_wablm), .sram_q(sram_q), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural macro: one access per enabled edge, read data appears after the edge.
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] <= sram_d;
            else            sram_q <= sram_mem[sram_a];
        end
    end

    // Reference model and scoreboards.
    typedef struct { int cyc; logic we; logic [AW-1:0] a; logic [DW-1:0] d; } acc_t;
    typedef struct { int cyc; logic [DW-1:0] d; } rsp_t;
    logic [DW-1:0] ref_mem [DEPTH];
    acc_t acc_q[$];
    rsp_t rsp_q[$];
    int   ready_from = 0;
    bit   awaiting   = 0;
    bit   prev_v     = 0;
    logic [DW-1:0] held = '0;

    int errors = 0;
    int checks = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
`ifdef SRAM_CTRL_INIT_EN
            sram_mem[i] = $urandom;
`else
            sram_mem[i] = '0;
`endif
        end
        sram_q = '0;
    end

    // Monitor: samples at the falling edge, compares against queued expectations.
    always @(negedge CLK) begin
        acc_t e;
        rsp_t r;
        bit   exp_rdy;
        check("margin_pins", {sram_stov, sram_ema, sram_emaw, sram_emas, sram_ret1n, sram_wabl, sram_wablm},
              {1'b0, 3'b011, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00});
        if (RST) begin
            check("reset_outputs", {sram_cen, sram_gwen, sram_a, sram_d, rsp_valid, rsp_rdata},
                  {1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}, 1'b0, {DW{1'b0}}});
            acc_q.delete();
            rsp_q.delete();
            awaiting = 0;
            prev_v   = 0;
            held     = '0;
`ifdef SRAM_CTRL_INIT_EN
            ready_from = cyc + 1 + DEPTH;
            for (int k = 0; k < DEPTH; k++) begin
                e.cyc = cyc + 2 + k; e.we = 1'b1; e.a = AW'(k); e.d = '0;
                acc_q.push_back(e);
                ref_mem[k] = '0;
            end
`else
            ready_from = cyc + 1;
`endif
        end else begin
            exp_rdy = !awaiting && (cyc >= ready_from);
            check("req_ready", req_ready, exp_rdy);
            check("busy", busy, !exp_rdy);

            if (!sram_cen) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_access_cen", sram_cen, 1'b1);
                end else begin
                    e = acc_q.pop_front();
                    check("access_cycle", cyc, e.cyc);
                    check("access_gwen", sram_gwen, !e.we);
                    check("access_addr", sram_a, e.a);
                    if (e.we) check("access_wdata", sram_d, e.d);
                end
            end else if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
                check("missing_access_cen", sram_cen, 1'b0);
                void'(acc_q.pop_front());
            end

            if (rsp_valid) begin
                if (!prev_v) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_rsp_valid", rsp_valid, 1'b0);
                    end else begin
                        r = rsp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, r.d);
                        check("rsp_latency", cyc, r.cyc + 3);
                    end
                    held = rsp_rdata;
                end else begin
                    check("rsp_stable", rsp_rdata, held);
                end
            end else if (prev_v) begin
                check("rsp_retain", rsp_rdata, held);
            end
            prev_v = rsp_valid;

            if (rsp_valid && rsp_ready) begin
                awaiting   = 0;
                ready_from = cyc + 1;
            end
            if (req_valid && req_ready) begin
                e.cyc = cyc + 1; e.we = req_we; e.a = req_addr; e.d = req_wdata;
                acc_q.push_back(e);
                if (req_we) begin
                    ref_mem[req_addr] = req_wdata;
                    ready_from = cyc + 2;
                end else begin
                    r.cyc = cyc; r.d = ref_mem[req_addr];
                    rsp_q.push_back(r);
                    awaiting = 1;
                end
            end
        end
    end

    // Response-side backpressure driver.
    int rsp_hold  = 0;
    bit rand_mode = 0;
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (rsp_hold > 0) begin
                rsp_ready = 1'b0;
                rsp_hold--;
            end else begin
                rsp_ready = rand_mode ? 1'($urandom % 2) : 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        forever begin
            @(negedge CLK);
            if (req_ready) break;
            n++;
            if (n > 2000) begin
                check("req_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge CLK);
            if (req_ready && !rsp_valid && rsp_q.size() == 0) break;
            n++;
            if (n > 2000) begin
                check("idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int n;
        RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

`ifdef SRAM_CTRL_INIT_EN
        // Reset in the middle of the sweep must restart it from address 0.
        n = 0;
        forever begin
            @(negedge CLK);
            if (!sram_cen && sram_a == AW'(100)) break;
            n++;
            if (n > 2000) begin check("sweep_timeout", 0, 1); break; end
        end
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        do_req(1'b0, AW'(DEPTH - 1), '0);
        wait_idle();
`endif

        // Basic write/read ordering.
        do_req(1'b1, 0, 5);
        do_req(1'b1, 1, 6);
        do_req(1'b1, 2, 7);
        do_req(1'b0, 0, 0);
        wait_idle();
        do_req(1'b0, 2, 0);
        wait_idle();
        do_req(1'b0, 1, 0);
        wait_idle();

        // Response stalled by the host.
        rsp_hold = 8;
        do_req(1'b0, 2, 0);
        wait_idle();

        // Back-to-back writes with valid held high.
        for (int i = 0; i < 4; i++) do_req(1'b1, AW'(10 + i), 32'hA0 + i);
        wait_idle();

        // Reset during WAIT of a read: no response, then stored data still readable.
        do_req(1'b0, 1, 0);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        do_req(1'b0, 1, 0);
        wait_idle();

        // Random traffic with random response backpressure.
        rand_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            req_valid = 1'($urandom % 2);
            req_we    = 1'($urandom % 2);
            req_addr  = ($urandom % 2) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, DEPTH - 1));
            req_wdata = $urandom;
            @(posedge CLK);
            #1;
        end
        req_valid = 1'b0;
        rand_mode = 0;
        wait_idle();
        repeat (3) @(posedge CLK);

        check("queues_drained", acc_q.size() + rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
